fetch_buffer: RTL

- Fetch-side producer of the Fetch-to-Decode handshake: issues in-order instruction-memory requests from a local PC, buffers returning words in a small FIFO, and presents them to Decode with valid/rdy.
- Handles misprediction redirects (pipe_flush + branch_pc) by emptying the FIFO and silently dropping responses still in flight.
- Sits between the instruction memory/cache port and the decode stage.

---
 rtl/fetch_buffer.sv | 105 ++++++++++
 1 files changed

// File: rtl/fetch_buffer.sv
// Fetch-side producer for the Fetch-to-Decode handshake: in-order instruction requests
// from a local PC, a small response FIFO, and redirect handling that drops stale acks.
module fetch_buffer #(
  parameter int               PC_SZ    = 32,
  parameter int               INSTR_SZ = 32,
  parameter int               DEPTH    = 4,
  parameter logic [PC_SZ-1:0] RESET_PC = '0
) (
  input  logic                clk_in,
  input  logic                reset_in,
  input  logic                cpu_halt,
  input  logic                pipe_flush,
  input  logic [PC_SZ-1:0]    branch_pc,
  output logic                ic_req_valid,
  input  logic                ic_req_rdy,
  output logic [PC_SZ-1:0]    ic_req_addr,
  input  logic                ic_ack_valid,
  input  logic [INSTR_SZ-1:0] ic_ack_data,
  input  logic                ic_ack_err,
  output logic                f2d_valid,
  input  logic                f2d_rdy,
  output logic [INSTR_SZ-1:0] f2d_instr,
  output logic [PC_SZ-1:0]    f2d_pc,
  output logic                f2d_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [INSTR_SZ-1:0] instr;
    logic                err;
    logic [PC_SZ-1:0]    pc;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          head;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   fifo_count, in_flight, in_flight_nxt, discard;
  logic [PC_SZ-1:0] pc, resp_pc;
  logic            credit_ok, req_fire, ack_ok, drop, push, pop;

  // Every request holds a FIFO slot until its word is popped, so overflow cannot occur.
  assign credit_ok    = ({1'b0, in_flight} + {1'b0, fifo_count}) < (CW+1)'(DEPTH);
  assign ic_req_valid = reset_in & ~cpu_halt & ~pipe_flush & credit_ok;
  assign ic_req_addr  = pc;

  assign req_fire = ic_req_valid & ic_req_rdy;
  assign ack_ok   = ic_ack_valid & (in_flight != '0);
  assign drop     = ack_ok & (pipe_flush | (discard != '0));
  assign push     = ack_ok & ~drop;
  assign pop      = f2d_valid & f2d_rdy & ~pipe_flush;

  assign in_flight_nxt = in_flight + CW'(req_fire) - CW'(ack_ok);

  assign head      = mem[rd_ptr];
  assign f2d_valid = (fifo_count != '0);
  assign f2d_instr = f2d_valid ? head.instr : '0;
  assign f2d_pc    = f2d_valid ? head.pc    : '0;
  assign f2d_err   = f2d_valid ? head.err   : 1'b0;

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      pc         <= RESET_PC;
      resp_pc    <= RESET_PC;
      in_flight  <= '0;
      discard    <= '0;
      fifo_count <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else begin
      in_flight <= in_flight_nxt;
      if (pipe_flush) begin
        // Everything still outstanding after this cycle belongs to the old path.
        pc         <= branch_pc;
        resp_pc    <= branch_pc;
        discard    <= in_flight_nxt;
        fifo_count <= '0;
        wr_ptr     <= '0;
        rd_ptr     <= '0;
      end else begin
        if (req_fire) pc <= pc + PC_SZ'(4);
        if (drop)     discard <= discard - CW'(1);
        if (push) begin
          wr_ptr  <= wr_ptr + PW'(1);
          resp_pc <= resp_pc + PC_SZ'(4);
        end
        if (pop) rd_ptr <= rd_ptr + PW'(1);
        fifo_count <= fifo_count + CW'(push) - CW'(pop);
      end
    end
  end

  // NOTE: the storage array is not reset; an entry is only read once fifo_count covers it.
  always_ff @(posedge clk_in) begin
    if (push) mem[wr_ptr] <= '{instr: ic_ack_data, err: ic_ack_err, pc: resp_pc};
  end

  a_ack_has_request: assert property (@(posedge clk_in) disable iff (!reset_in)
    ic_ack_valid |-> (in_flight != '0));

  a_counters_bounded: assert property (@(posedge clk_in) disable iff (!reset_in)
    (in_flight <= CW'(DEPTH)) && (fifo_count <= CW'(DEPTH)) && (discard <= in_flight));

endmodule
